alu_mult_ctrl: RTL and testbench

Multi-cycle sequencer that performs a 16x16 unsigned shift-and-add multiply using the shared 16-bit combinational ALU. The block drives the ALU's `R`, `S` and `alu_op` inputs and samples its `Y` and `C` outputs. It sits between the instruction control unit, which issues `start`, and the ALU. While the sequencer is busy it owns the ALU; the results are a 32-bit product and an overflow flag.

---
 rtl/alu_mult_ctrl.sv | 112 +++++++++++
 tb/tb_alu_mult_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_mult_ctrl.sv
// rtl/alu_mult_ctrl.sv - 16x16 unsigned shift-and-add multiply sequencer driving the shared ALU
module alu_mult_ctrl #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] prod_hi,
    output logic [WIDTH-1:0] prod_lo,
    output logic             ovf,
    output logic [WIDTH-1:0] alu_r,
    output logic [WIDTH-1:0] alu_s,
    output logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] alu_y,
    input  logic             alu_c
);

    localparam logic [3:0]       OP_ADD  = 4'b0100;
    localparam logic [3:0]       OP_PASS = 4'b0000;
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    assign prod_hi = acc_hi;
    assign prod_lo = acc_lo;
    assign ovf     = |acc_hi;

    // ALU bus is registered one cycle ahead so it is stable for the whole ADD cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            mcand  <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            alu_op <= OP_PASS;
            alu_r  <= '0;
            alu_s  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        mcand  <= a_in;
                        acc_lo <= b_in;
                        acc_hi <= '0;
                        carry  <= 1'b0;
                        cnt    <= '0;
                        busy   <= 1'b1;
                        alu_op <= OP_ADD;
                        alu_r  <= '0;
                        alu_s  <= a_in;
                        state  <= ADD;
                    end
                end
                ADD: begin
                    if (acc_lo[0]) begin
                        carry  <= alu_c;
                        acc_hi <= alu_y;
                    end else begin
                        carry  <= 1'b0;
                    end
                    alu_op <= OP_PASS;
                    alu_r  <= '0;
                    alu_s  <= '0;
                    state  <= SHIFT;
                end
                SHIFT: begin
                    acc_hi <= {carry, acc_hi[WIDTH-1:1]};
                    acc_lo <= {acc_hi[0], acc_lo[WIDTH-1:1]};
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == LAST) begin
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        alu_op <= OP_ADD;
                        alu_r  <= {carry, acc_hi[WIDTH-1:1]};
                        alu_s  <= mcand;
                        state  <= ADD;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mult_ctrl.sv
// tb/tb_alu_mult_ctrl.sv - directed and randomized checks of alu_mult_ctrl against a product model
module tb_alu_mult_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a_in;
    logic [15:0] b_in;
    logic        busy;
    logic        done;
    logic [15:0] prod_hi;
    logic [15:0] prod_lo;
    logic        ovf;
    logic [15:0] alu_r;
    logic [15:0] alu_s;
    logic [3:0]  alu_op;
    logic [15:0] alu_y;
    logic        alu_c;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Behavioural shared ALU: add or pass S.
    assign {alu_c, alu_y} = (alu_op == 4'b0100) ? ({1'b0, alu_r} + {1'b0, alu_s}) : {1'b0, alu_s};

    alu_mult_ctrl dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .a_in    (a_in),
        .b_in    (b_in),
        .busy    (busy),
        .done    (done),
        .prod_hi (prod_hi),
        .prod_lo (prod_lo),
        .ovf     (ovf),
        .alu_r   (alu_r),
        .alu_s   (alu_s),
        .alu_op  (alu_op),
        .alu_y   (alu_y),
        .alu_c   (alu_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One multiply started from IDLE; optional stray start pulse in cycle pulse_at (0 = none).
    task automatic run_mul(input logic [15:0] a, input logic [15:0] b, input int pulse_at,
                           input logic [15:0] a2, input logic [15:0] b2);
        logic [31:0] expv;
        logic [31:0] got_p;
        logic        got_ovf;
        logic [3:0]  exp_op;
        int done_cycle;
        int done_cnt;
        int busy_err;
        int op_err;
        int adds;
        expv       = {16'h0, a} * {16'h0, b};
        got_p      = '0;
        got_ovf    = 1'b0;
        done_cycle = -1;
        done_cnt   = 0;
        busy_err   = 0;
        op_err     = 0;
        adds       = 0;
        @(negedge clk);
        start = 1'b1;
        a_in  = a;
        b_in  = b;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            start = (k == pulse_at);
            if (k == pulse_at) begin
                a_in = a2;
                b_in = b2;
            end
            if (busy !== logic'(k <= 33)) busy_err++;
            exp_op = (k <= 32 && (k % 2) == 1) ? 4'b0100 : 4'b0000;
            if (alu_op !== exp_op) op_err++;
            if (alu_op === 4'b0100) begin
                adds++;
                if (alu_s !== a) op_err++;
            end else if (alu_r !== 16'h0 || alu_s !== 16'h0) begin
                op_err++;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_cycle < 0) begin
                    done_cycle = k;
                    got_p      = {prod_hi, prod_lo};
                    got_ovf    = ovf;
                end
            end
        end
        check($sformatf("done_cycle %h*%h", a, b), 32'(done_cycle), 32'd33);
        check($sformatf("done_count %h*%h", a, b), 32'(done_cnt), 32'd1);
        check($sformatf("product %h*%h", a, b), got_p, expv);
        check($sformatf("ovf %h*%h", a, b), {31'h0, got_ovf}, {31'h0, expv > 32'h0000FFFF});
        check($sformatf("add_count %h*%h", a, b), 32'(adds), 32'd16);
        check($sformatf("alu_bus_errs %h*%h", a, b), 32'(op_err), 32'd0);
        check($sformatf("busy_errs %h*%h", a, b), 32'(busy_err), 32'd0);
        check($sformatf("product_hold %h*%h", a, b), {prod_hi, prod_lo}, expv);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, " busy"}, {31'h0, busy}, 32'h0);
        check({tag, " done"}, {31'h0, done}, 32'h0);
        check({tag, " prod"}, {prod_hi, prod_lo}, 32'h0);
        check({tag, " ovf"}, {31'h0, ovf}, 32'h0);
        check({tag, " alu_bus"}, {alu_op, alu_r[11:0], alu_s}, 32'h0);
    endtask

    initial begin
        logic [15:0] pa [3];
        logic [15:0] pb [3];
        logic [31:0] got [3];
        int          dc [3];
        int          nd;
        int          busy_err;
        int          stray_done;

        rst_n = 1'b0;
        start = 1'b0;
        a_in  = 16'h0;
        b_in  = 16'h0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        run_mul(16'd3, 16'd5, 0, 16'h0, 16'h0);
        run_mul(16'hFFFF, 16'hFFFF, 0, 16'h0, 16'h0);
        run_mul(16'h1234, 16'h0000, 0, 16'h0, 16'h0);
        run_mul(16'h0000, 16'hABCD, 0, 16'h0, 16'h0);
        run_mul(16'h00C3, 16'h0111, 10, 16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 4; i++) begin
            run_mul(16'($urandom), 16'($urandom), 0, 16'h0, 16'h0);
        end

        // Reset dropped mid-multiply, 12 cycles after acceptance.
        @(negedge clk);
        start = 1'b1;
        a_in  = 16'hBEEF;
        b_in  = 16'hCAFE;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            start = 1'b0;
        end
        #2 rst_n = 1'b0;
        #1 check_zero_outputs("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        stray_done = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) stray_done++;
        end
        check("no_done_after_reset", 32'(stray_done), 32'd0);
        run_mul(16'h0100, 16'h0100, 0, 16'h0, 16'h0);

        // Back-to-back with start held high.
        for (int i = 0; i < 3; i++) begin
            pa[i]  = 16'($urandom);
            pb[i]  = 16'($urandom);
            got[i] = '0;
            dc[i]  = -1;
        end
        nd       = 0;
        busy_err = 0;
        @(negedge clk);
        start = 1'b1;
        a_in  = pa[0];
        b_in  = pb[0];
        for (int k = 1; k <= 103; k++) begin
            @(negedge clk);
            if (k == 34 || k == 68) begin
                a_in = pa[k / 34];
                b_in = pb[k / 34];
            end
            if (k == 102) start = 1'b0;
            if (busy !== !(k == 34 || k == 68 || k >= 102)) busy_err++;
            if (done === 1'b1) begin
                if (nd < 3) begin
                    got[nd] = {prod_hi, prod_lo};
                    dc[nd]  = k;
                end
                nd++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 32'(nd), 32'd3);
        check("b2b_busy_errs", 32'(busy_err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("b2b_done_cycle[%0d]", i), 32'(dc[i]), 32'(33 + 34 * i));
            check($sformatf("b2b_product[%0d]", i), got[i], {16'h0, pa[i]} * {16'h0, pb[i]});
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
